// File: rtl/smp_pkg.sv
// Shared types and constants for the sample/start sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
package smp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    GAP     = 2'd3
  } state_e;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_SCAN   = 2'd1;
  localparam logic [1:0] MODE_CONT   = 2'd2;

  // Largest of three values; used to size the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/smp_down_cnt.sv
// Loadable down-counter that saturates at zero, with a zero flag.
// Latency: load and decrement take effect on the next rising edge.
// Backpressure: none; load has priority over decrement.
module smp_down_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Load on request, otherwise count down and stick at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/smp_seq_ctrl.sv
// Sample/start sequencer for the SAR ADC: sampling pulse, conversion hold, round-robin channels.
// Latency: trig at edge k -> samp after k, start after k+max(samp_cyc,1); all outputs registered.
// Backpressure: trig accepted only in IDLE with eoc low; requests while busy are dropped.
module smp_seq_ctrl
  import smp_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int SCW     = 4,
  parameter int GAP_CYC = 2,
  parameter int TMO_CYC = 64,
  parameter int CHW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [1:0]     mode,
  input  logic           trig,
  input  logic [SCW-1:0] samp_cyc,
  input  logic           eoc,
  output logic           samp,
  output logic           start,
  output logic [CHW-1:0] ch_sel,
  output logic           conv_done,
  output logic           timeout,
  output logic           scan_done,
  output logic           busy
);

  // One counter serves every phase, so it must hold the longest of them.
  localparam int CNT_MAX = max3((1 << SCW) - 1, GAP_CYC, TMO_CYC);
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  localparam logic [CNTW-1:0] TMO_VAL  = CNTW'(TMO_CYC - 1);
  localparam logic [CNTW-1:0] GAP_VAL  = CNTW'(GAP_CYC);
  localparam logic [CHW-1:0]  LAST_CH  = CHW'(N_CH - 1);

  state_e          state_q, state_d;
  logic            samp_q, samp_d;
  logic            start_q, start_d;
  logic            conv_done_q, conv_done_d;
  logic            timeout_q, timeout_d;
  logic            scan_done_q, scan_done_d;
  logic            busy_q;
  logic [CHW-1:0]  ch_sel_q, ch_sel_d;
  logic            cnt_load;
  logic [CNTW-1:0] cnt_val;
  logic            cnt_zero;
  logic [CNTW-1:0] samp_val;
  logic            last_ch;

  // A zero sample length is treated as one cycle; counter holds length-1.
  assign samp_val = (samp_cyc == '0) ? '0 : CNTW'(samp_cyc - SCW'(1));
  assign last_ch  = (ch_sel_q == LAST_CH);

  smp_down_cnt #(.W(CNTW)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (cnt_load),
    .val_i  (cnt_val),
    .zero_o (cnt_zero)
  );

  // Next-state, next-output and counter-load decisions for every phase.
  always_comb begin
    state_d     = state_q;
    samp_d      = 1'b0;
    start_d     = 1'b0;
    conv_done_d = 1'b0;
    timeout_d   = 1'b0;
    scan_done_d = 1'b0;
    ch_sel_d    = ch_sel_q;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    unique case (state_q)
      IDLE: begin
        if (!eoc && (trig || mode == MODE_CONT)) begin
          state_d  = SAMPLE;
          samp_d   = 1'b1;
          ch_sel_d = '0;
          cnt_load = 1'b1;
          cnt_val  = samp_val;
        end
      end
      SAMPLE: begin
        if (cnt_zero) begin
          state_d  = CONVERT;
          start_d  = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = TMO_VAL;
        end else begin
          samp_d = 1'b1;
        end
      end
      CONVERT: begin
        // eoc is checked first so it wins over a coincident timeout.
        if (eoc) begin
          state_d     = GAP;
          conv_done_d = 1'b1;
          cnt_load    = 1'b1;
          cnt_val     = GAP_VAL;
        end else if (cnt_zero) begin
          state_d   = GAP;
          timeout_d = 1'b1;
          cnt_load  = 1'b1;
          cnt_val   = GAP_VAL;
        end else begin
          start_d = 1'b1;
        end
      end
      GAP: begin
        if (cnt_zero && !eoc) begin
          if (mode == MODE_SCAN && last_ch) begin
            scan_done_d = 1'b1;
            ch_sel_d    = '0;
            state_d     = IDLE;
          end else if (mode == MODE_SCAN || mode == MODE_CONT) begin
            if (last_ch) begin
              scan_done_d = 1'b1;
              ch_sel_d    = '0;
            end else begin
              ch_sel_d = ch_sel_q + CHW'(1);
            end
            state_d  = SAMPLE;
            samp_d   = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = samp_val;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
    // Disable abandons whatever is in flight and parks everything at zero.
    if (!en) begin
      state_d     = IDLE;
      samp_d      = 1'b0;
      start_d     = 1'b0;
      conv_done_d = 1'b0;
      timeout_d   = 1'b0;
      scan_done_d = 1'b0;
      ch_sel_d    = '0;
      cnt_load    = 1'b1;
      cnt_val     = '0;
    end
  end

  // FSM state and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      samp_q      <= 1'b0;
      start_q     <= 1'b0;
      conv_done_q <= 1'b0;
      timeout_q   <= 1'b0;
      scan_done_q <= 1'b0;
      busy_q      <= 1'b0;
      ch_sel_q    <= '0;
    end else begin
      state_q     <= state_d;
      samp_q      <= samp_d;
      start_q     <= start_d;
      conv_done_q <= conv_done_d;
      timeout_q   <= timeout_d;
      scan_done_q <= scan_done_d;
      busy_q      <= (state_d != IDLE);
      ch_sel_q    <= ch_sel_d;
    end
  end

  assign samp      = samp_q;
  assign start     = start_q;
  assign conv_done = conv_done_q;
  assign timeout   = timeout_q;
  assign scan_done = scan_done_q;
  assign busy      = busy_q;
  assign ch_sel    = ch_sel_q;

endmodule

// File: tb/tb_smp_seq_ctrl.sv
// Directed bench for smp_seq_ctrl with N_CH=4, SCW=4, GAP_CYC=2, TMO_CYC=64.
// Outputs are packed as {samp,start,conv_done,timeout,scan_done,busy,ch_sel[1:0]}
// and compared 1 time unit after each rising edge.
module tb_smp_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       trig;
  logic [3:0] samp_cyc;
  logic       eoc;
  logic       samp;
  logic       start;
  logic [1:0] ch_sel;
  logic       conv_done;
  logic       timeout;
  logic       scan_done;
  logic       busy;

  int n_cmp;
  int n_err;

  smp_seq_ctrl #(
    .N_CH    (4),
    .SCW     (4),
    .GAP_CYC (2),
    .TMO_CYC (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .trig      (trig),
    .samp_cyc  (samp_cyc),
    .eoc       (eoc),
    .samp      (samp),
    .start     (start),
    .ch_sel    (ch_sel),
    .conv_done (conv_done),
    .timeout   (timeout),
    .scan_done (scan_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {samp, start, conv_done, timeout, scan_done, busy, ch_sel};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Starts just after the SAMPLE-entry edge for channel ch with samp_cyc=2;
  // eoc is returned after one CONVERT cycle; exp_exit is the state after GAP.
  task automatic conv(input logic [1:0] ch, input logic [7:0] exp_exit);
    logic [7:0] c;
    c = {6'b0, ch};
    tick(1); chk($sformatf("ch%0d_samp2", ch), 8'h84 | c);
    tick(1); chk($sformatf("ch%0d_start", ch), 8'h44 | c);
    eoc = 1'b1;
    tick(1); chk($sformatf("ch%0d_done", ch), 8'h24 | c);
    eoc = 1'b0;
    tick(2); chk($sformatf("ch%0d_gap", ch), 8'h04 | c);
    tick(1); chk($sformatf("ch%0d_exit", ch), exp_exit);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    mode     = 2'd0;
    trig     = 1'b0;
    samp_cyc = 4'd3;
    eoc      = 1'b0;

    // Reset state
    tick(2); chk("reset", 8'h00);
    rst_n = 1'b1;
    en    = 1'b1;
    tick(1); chk("idle_no_trig", 8'h00);

    // Single conversion, samp_cyc=3, eoc five cycles into CONVERT
    trig = 1'b1;
    tick(1); chk("s_samp1", 8'h84);
    trig = 1'b0;
    tick(1); chk("s_samp2", 8'h84);
    tick(1); chk("s_samp3", 8'h84);
    tick(1); chk("s_start", 8'h44);
    tick(4); chk("s_start5", 8'h44);
    eoc = 1'b1;
    tick(1); chk("s_done", 8'h24);
    eoc = 1'b0;
    tick(1); chk("s_done_pulse", 8'h04);
    tick(1); chk("s_gap2", 8'h04);
    tick(1); chk("s_idle", 8'h00);

    // samp_cyc=0, trig held while busy, eoc held through GAP
    samp_cyc = 4'd0;
    trig     = 1'b1;
    tick(1); chk("z_samp", 8'h84);
    tick(1); chk("z_start", 8'h44);
    tick(1); chk("z_start2", 8'h44);
    eoc = 1'b1;
    tick(1); chk("z_done", 8'h24);
    tick(3); chk("z_gap_eoc", 8'h04);
    tick(1); chk("z_gap_hold", 8'h04);
    eoc  = 1'b0;
    trig = 1'b0;
    tick(1); chk("z_idle", 8'h00);
    tick(1); chk("z_no_queue", 8'h00);
    eoc  = 1'b1;
    trig = 1'b1;
    tick(1); chk("idle_eoc_block", 8'h00);
    eoc  = 1'b0;
    trig = 1'b0;
    tick(1); chk("trig_not_latched", 8'h00);

    // Scan-once over four channels
    samp_cyc = 4'd2;
    mode     = 2'd1;
    trig     = 1'b1;
    tick(1); chk("scan_entry", 8'h84);
    trig = 1'b0;
    conv(2'd0, 8'h85);
    conv(2'd1, 8'h86);
    conv(2'd2, 8'h87);
    conv(2'd3, 8'h08);
    tick(1); chk("scan_idle", 8'h00);

    // Continuous with a missing eoc on channel 0, then wrap
    mode = 2'd2;
    tick(1); chk("cont_entry", 8'h84);
    tick(1); chk("cont_samp2", 8'h84);
    tick(1); chk("cont_start", 8'h44);
    tick(63); chk("cont_start64", 8'h44);
    tick(1); chk("cont_timeout", 8'h14);
    tick(2); chk("cont_tmo_gap", 8'h04);
    tick(1); chk("cont_next_ch", 8'h85);
    conv(2'd1, 8'h86);
    conv(2'd2, 8'h87);
    conv(2'd3, 8'h8C);
    conv(2'd0, 8'h85);

    // Disable during SAMPLE on channel 1, re-enable restarts at channel 0
    en = 1'b0;
    tick(1); chk("en_drop", 8'h00);
    en = 1'b1;
    tick(1); chk("reen_ch0", 8'h84);

    // Reset in the middle of CONVERT with eoc arriving at the reset edge
    tick(2); chk("pre_rst_conv", 8'h44);
    rst_n = 1'b0;
    eoc   = 1'b1;
    tick(1); chk("rst_mid_conv", 8'h00);
    rst_n = 1'b1;
    eoc   = 1'b0;
    en    = 1'b0;
    tick(1); chk("post_rst_no_done", 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/smp_seq_ctrl.md
Name: smp_seq_ctrl

Overview:
Parametrised successor to the sample/start sequencer for the time-domain SAR ADC. It generates a programmable-width sampling pulse, then holds the conversion-start level until the SAR core returns eoc. Channels are multiplexed round-robin with a settle gap between conversions, and a conversion timeout recovers from a missing eoc. Sits between the top-level control registers and the S/H switch, comparator/SAR core and input mux.

Parameters:
N_CH, 4, number of analog input channels (1..16)
SCW, 4, width of runtime samp_cyc field
GAP_CYC, 2, idle cycles between eoc and next sampling phase (0 allowed)
TMO_CYC, 64, max cycles in CONVERT before timeout (>=1)
CHW, $clog2(N_CH) (min 1), channel index width, derived

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
en  in  1  block enable; low forces IDLE synchronously
mode  in  2  0=single, 1=scan-once, 2=continuous, 3=reserved (treated as single)
trig  in  1  conversion request, single-cycle or level; sampled in IDLE only
samp_cyc  in  SCW  sampling phase length in cycles; 0 treated as 1
eoc  in  1  end-of-conversion from SAR core, level
samp  out  1  S/H switch control, high during SAMPLE
start  out  1  conversion start, high during CONVERT
ch_sel  out  CHW  channel mux select, stable from SAMPLE entry to GAP exit
conv_done  out  1  one-cycle pulse on accepted eoc
timeout  out  1  one-cycle pulse on conversion timeout
scan_done  out  1  one-cycle pulse when last channel of a scan completes (modes 1, 2)
busy  out  1  high in any state other than IDLE

Behaviour:
- Everything is registered; outputs change only on rising clk.
- Reset (rst_n=0 at an edge): state=IDLE; samp, start, conv_done, timeout, scan_done, busy=0; ch_sel=0; all counters=0. Reset has priority over en.
- en=0 at an edge, any state: next state IDLE, samp=start=0, ch_sel=0, pulses=0. An in-flight conversion is abandoned with no conv_done.
- IDLE: go to SAMPLE when en=1, eoc=0, and (trig=1 or mode=2).
  - If eoc=1, wait in IDLE; trig is not latched.
  - On entry: samp=1; samp_cyc latched (0 becomes 1); ch_sel=0 when starting from IDLE.
- SAMPLE: samp high for exactly max(samp_cyc,1) cycles, then CONVERT (samp=0, start=1 on the same edge). samp and start are never high together.
- CONVERT:
  - On eoc=1: start=0, conv_done=1 for one cycle, go to GAP.
  - If TMO_CYC cycles elapse with no eoc: start=0, timeout=1 for one cycle, go to GAP. The channel still advances.
  - If eoc and timeout occur in the same cycle, eoc wins.
- GAP: count GAP_CYC cycles, then additionally wait for eoc=0. On exit:
  - mode 0: go to IDLE; ch_sel unchanged.
  - mode 1: if ch_sel=N_CH-1, pulse scan_done, set ch_sel=0, go to IDLE; else ch_sel+1 and SAMPLE.
  - mode 2: ch_sel wraps modulo N_CH; scan_done pulses on wrap; go to SAMPLE.
  - A mode change takes effect at the next GAP exit.
- Latency: trig sampled at edge k gives samp=1 after edge k, and start=1 after edge k+samp_cyc.
- trig while busy is ignored, not queued.
- N_CH=1: ch_sel is a constant 0; scan_done pulses every conversion in modes 1 and 2.
- Counters are sized to hold max(2^SCW-1, GAP_CYC, TMO_CYC) and saturate, never wrap.

Decomposition:
- Shared package smp_pkg: state enum {IDLE, SAMPLE, CONVERT, GAP}, mode constants MODE_SINGLE/MODE_SCAN/MODE_CONT.
- One natural sub-module, smp_down_cnt: loadable down-counter with a zero flag, width-parametrised. It is reused for the sample, gap and timeout counts.

Test Plan:
- Reset mid-CONVERT (rst_n=0 one cycle) -> next cycle all outputs 0, ch_sel=0; no conv_done.
- mode=0, samp_cyc=3, trig pulse, eoc rises 5 cycles after start -> samp high exactly 3 cycles, then start; conv_done 1 cycle; busy clears after GAP_CYC+1.
- mode=1, N_CH=4, eoc returned each conversion -> ch_sel 0,1,2,3; four conv_done pulses; scan_done with the last one; IDLE and ch_sel=0 afterwards.
- mode=2, eoc never returned, TMO_CYC=64 -> start high 64 cycles then timeout pulse, ch_sel advances, sequence continues.
- samp_cyc=0 -> samp high 1 cycle. eoc held high through GAP -> no SAMPLE until eoc=0. trig while busy -> no extra conversion.
- en dropped during SAMPLE -> samp=0 next cycle, IDLE; re-enable with mode=2 -> restarts at ch_sel=0.
